// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the 2:1 AXI4 arbiter in front of the simulation SRAM.
package axi_arb_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRd0,
        StRd1,
        StWrAw,
        StWrW,
        StWrB
    } arb_state_e;

    typedef enum logic {
        MstM0 = 1'b0,
        MstM1 = 1'b1
    } mst_idx_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY      = 2'b00;
    localparam logic [1:0] RESP_SLVERR    = 2'b10;

endpackage

// File: rtl/axi_arb_2x1_rr_arb2.sv
// Two-requester round-robin picker. The pointer names the side that wins a tie and
// moves to the other side whenever a grant is taken (advance high with a request).
module rr_arb2
    import axi_arb_pkg::*;
(
    input  logic       aclk,
    input  logic       aresetn,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt,
    output logic       ptr
);

    mst_idx_e ptr_q;

    // One-hot grant: a lone requester always wins, a tie goes to the pointer side.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (ptr_q == MstM1) ? 2'b10 : 2'b01;
        end
    end

    // Pointer update on a taken grant; the winner drops to lowest priority.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            ptr_q <= MstM0;
        end else if (advance && (gnt != 2'b00)) begin
            ptr_q <= gnt[0] ? MstM1 : MstM0;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/axi_arb_2x1.sv
// 2:1 AXI4 arbiter: m0 (fetch, read-only) and m1 (load/store) onto one SRAM slave port,
// one burst in flight at a time. Optional watchdog under `ARB_TIMEOUT_EN`.
module axi_arb_2x1
    import axi_arb_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 64,
    parameter int unsigned ID_W           = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                aclk,
    input  logic                aresetn,
    // m0 read
    input  logic [ADDR_W-1:0]   m0_araddr,
    input  logic [ID_W-1:0]     m0_arid,
    input  logic [7:0]          m0_arlen,
    input  logic [2:0]          m0_arsize,
    input  logic [1:0]          m0_arburst,
    input  logic                m0_arvalid,
    output logic                m0_arready,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic [ID_W-1:0]     m0_rid,
    output logic [1:0]          m0_rresp,
    output logic                m0_rlast,
    output logic                m0_rvalid,
    input  logic                m0_rready,
    // m1 read
    input  logic [ADDR_W-1:0]   m1_araddr,
    input  logic [ID_W-1:0]     m1_arid,
    input  logic [7:0]          m1_arlen,
    input  logic [2:0]          m1_arsize,
    input  logic [1:0]          m1_arburst,
    input  logic                m1_arvalid,
    output logic                m1_arready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [ID_W-1:0]     m1_rid,
    output logic [1:0]          m1_rresp,
    output logic                m1_rlast,
    output logic                m1_rvalid,
    input  logic                m1_rready,
    // m1 write
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic [ID_W-1:0]     m1_awid,
    input  logic [7:0]          m1_awlen,
    input  logic [2:0]          m1_awsize,
    input  logic [1:0]          m1_awburst,
    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_wlast,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    output logic [ID_W-1:0]     m1_bid,
    output logic [1:0]          m1_bresp,
    output logic                m1_bvalid,
    input  logic                m1_bready,
    // slave port
    output logic [ADDR_W-1:0]   s_araddr,
    output logic [ID_W-1:0]     s_arid,
    output logic [7:0]          s_arlen,
    output logic [2:0]          s_arsize,
    output logic [1:0]          s_arburst,
    output logic                s_arlock,
    output logic [3:0]          s_arcache,
    output logic [2:0]          s_arprot,
    output logic                s_arvalid,
    input  logic                s_arready,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [ID_W-1:0]     s_rid,
    input  logic [1:0]          s_rresp,
    input  logic                s_rlast,
    input  logic                s_rvalid,
    output logic                s_rready,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic [ID_W-1:0]     s_awid,
    output logic [7:0]          s_awlen,
    output logic [2:0]          s_awsize,
    output logic [1:0]          s_awburst,
    output logic                s_awlock,
    output logic [3:0]          s_awcache,
    output logic [2:0]          s_awprot,
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_wlast,
    output logic                s_wvalid,
    input  logic                s_wready,
    input  logic [ID_W-1:0]     s_bid,
    input  logic [1:0]          s_bresp,
    input  logic                s_bvalid,
    output logic                s_bready,
    // status
    output logic                busy,
    output logic                timeout_err
);

    arb_state_e state_q, state_d;
    logic       ar_done_q, ar_done_d;       // AR handshake already made for this burst
    logic [7:0] cnt_q, cnt_d;               // W beats accepted before the current one
    logic [7:0] awlen_q, awlen_d;
    logic       slverr_q, slverr_d;         // burst length disagreed with awlen
    logic       wlast_seen_q, wlast_seen_d; // whole W burst went through while still in WR_AW
    logic [1:0] gnt;
    logic       rr_ptr;
    mst_idx_e   rd_mst;

    rr_arb2 u_rr_arb2 (
        .aclk    (aclk),
        .aresetn (aresetn),
        .req     ({m1_arvalid | m1_awvalid, m0_arvalid}),
        .advance (state_q == StIdle),
        .gnt     (gnt),
        .ptr     (rr_ptr)
    );

    // Address/data paths are steered unconditionally; only valid/ready are gated by state.
    assign rd_mst    = (state_q == StRd1) ? MstM1 : MstM0;
    assign s_araddr  = (rd_mst == MstM1) ? m1_araddr  : m0_araddr;
    assign s_arid    = (rd_mst == MstM1) ? m1_arid    : m0_arid;
    assign s_arlen   = (rd_mst == MstM1) ? m1_arlen   : m0_arlen;
    assign s_arsize  = (rd_mst == MstM1) ? m1_arsize  : m0_arsize;
    assign s_arburst = (rd_mst == MstM1) ? m1_arburst : m0_arburst;
    assign s_arlock  = 1'b0;
    assign s_arcache = 4'b0;
    assign s_arprot  = 3'b0;
    assign s_awaddr  = m1_awaddr;
    assign s_awid    = m1_awid;
    assign s_awlen   = m1_awlen;
    assign s_awsize  = m1_awsize;
    assign s_awburst = m1_awburst;
    assign s_awlock  = 1'b0;
    assign s_awcache = 4'b0;
    assign s_awprot  = 3'b0;
    assign s_wdata   = m1_wdata;
    assign s_wstrb   = m1_wstrb;
    assign s_wlast   = m1_wlast;
    assign m0_rdata  = s_rdata;
    assign m0_rid    = s_rid;
    assign m0_rresp  = s_rresp;
    assign m0_rlast  = s_rlast;
    assign m1_rdata  = s_rdata;
    assign m1_rid    = s_rid;
    assign m1_rresp  = s_rresp;
    assign m1_rlast  = s_rlast;
    assign m1_bid    = s_bid;
    assign m1_bresp  = slverr_q ? RESP_SLVERR : s_bresp;
    assign busy      = (state_q != StIdle);

`ifdef ARB_TIMEOUT_EN
    logic [15:0] tmo_q;
    logic        tmo_err_q;
    logic        tmo_hit;
    assign tmo_hit     = (state_q != StIdle) && (tmo_q == 16'(TIMEOUT_CYCLES - 1));
    assign timeout_err = tmo_err_q;
`else
    logic [16:0] unused_cfg;
    assign unused_cfg  = {rr_ptr, 16'(TIMEOUT_CYCLES)};
    assign timeout_err = 1'b0;
`endif

    // Next-state and handshake gating; every valid/ready defaults low.
    always_comb begin
        state_d      = state_q;
        ar_done_d    = ar_done_q;
        cnt_d        = cnt_q;
        awlen_d      = awlen_q;
        slverr_d     = slverr_q;
        wlast_seen_d = wlast_seen_q;
        s_arvalid    = 1'b0;
        m0_arready   = 1'b0;
        m1_arready   = 1'b0;
        m0_rvalid    = 1'b0;
        m1_rvalid    = 1'b0;
        s_rready     = 1'b0;
        s_awvalid    = 1'b0;
        m1_awready   = 1'b0;
        s_wvalid     = 1'b0;
        m1_wready    = 1'b0;
        m1_bvalid    = 1'b0;
        s_bready     = 1'b0;
        unique case (state_q)
            StIdle: begin
                ar_done_d    = 1'b0;
                cnt_d        = '0;
                slverr_d     = 1'b0;
                wlast_seen_d = 1'b0;
                if (gnt[0]) begin
                    state_d = StRd0;
                end else if (gnt[1]) begin
                    state_d = m1_awvalid ? StWrAw : StRd1;  // writes beat reads within m1
                end
            end
            StRd0: begin
                s_arvalid  = m0_arvalid & ~ar_done_q;
                m0_arready = s_arready & ~ar_done_q;
                m0_rvalid  = s_rvalid;
                s_rready   = m0_rready;
            end
            StRd1: begin
                s_arvalid  = m1_arvalid & ~ar_done_q;
                m1_arready = s_arready & ~ar_done_q;
                m1_rvalid  = s_rvalid;
                s_rready   = m1_rready;
            end
            StWrAw: begin
                s_awvalid  = m1_awvalid;
                m1_awready = s_awready;
                s_wvalid   = m1_wvalid & ~wlast_seen_q;
                m1_wready  = s_wready & ~wlast_seen_q;
                if (s_wvalid && s_wready) begin
                    if (m1_wlast) begin
                        wlast_seen_d = 1'b1;
                        slverr_d     = (cnt_q != m1_awlen);
                    end else if (cnt_q != m1_awlen) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                if (s_awvalid && s_awready) begin
                    awlen_d = m1_awlen;
                    state_d = wlast_seen_d ? StWrB : StWrW;
                end
            end
            StWrW: begin
                s_wvalid  = m1_wvalid;
                m1_wready = s_wready;
                if (s_wvalid && s_wready) begin
                    if (m1_wlast) begin
                        slverr_d = (cnt_q != awlen_q);
                        state_d  = StWrB;
                    end else if (cnt_q != awlen_q) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            StWrB: begin
                s_bready  = m1_bready;
                m1_bvalid = s_bvalid;
                if (s_bvalid && m1_bready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (s_arvalid && s_arready) begin
            ar_done_d = 1'b1;
        end
        if (s_rvalid && s_rready && s_rlast) begin
            state_d = StIdle;
        end
`ifdef ARB_TIMEOUT_EN
        if (tmo_hit) begin
            state_d = StIdle;
        end
`endif
    end

    // State and burst-tracking registers, synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= StIdle;
            ar_done_q    <= 1'b0;
            cnt_q        <= '0;
            awlen_q      <= '0;
            slverr_q     <= 1'b0;
            wlast_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ar_done_q    <= ar_done_d;
            cnt_q        <= cnt_d;
            awlen_q      <= awlen_d;
            slverr_q     <= slverr_d;
            wlast_seen_q <= wlast_seen_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Watchdog: restarts on every state change, counts while a grant is held.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            tmo_q     <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            if (state_d != state_q) begin
                tmo_q <= '0;
            end else if (state_q != StIdle) begin
                tmo_q <= tmo_q + 16'd1;
            end
            if (tmo_hit) begin
                tmo_err_q <= 1'b1;
`ifndef SYNTHESIS
                $display("axi_arb_2x1: watchdog expired in %s, granted m%0d (rr_ptr %0d)",
                         state_q.name(), (state_q == StRd0) ? 0 : 1, rr_ptr);
`endif
            end
        end
    end
`endif

endmodule
